// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

    // Sweep controller states.
    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Storage depth for a given address width.
    function automatic int rf_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Low bit of the slice belonging to port k in a flattened port bus.
    function automatic int rf_slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: storage mux, write-through bypass, zero-register
// and not-ready masking.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int DEPTH    = rf_depth(ADDR_SIZE)
) (
    input  logic                            ready_i,
    input  logic [ADDR_SIZE-1:0]            raddr_i,
    input  logic                            we0_i,
    input  logic [ADDR_SIZE-1:0]            waddr0_i,
    input  logic [WORD_SIZE-1:0]            wdata0_i,
    input  logic                            we1_i,
    input  logic [ADDR_SIZE-1:0]            waddr1_i,
    input  logic [WORD_SIZE-1:0]            wdata1_i,
    input  logic [DEPTH-1:0][WORD_SIZE-1:0] mem_i,
    output logic [WORD_SIZE-1:0]            rdata_o
);

    // Priority: not ready, zero register, lane 1 bypass, lane 0 bypass, storage.
    always_comb begin
        rdata_o = '0;
        if (!ready_i) begin
            rdata_o = '0;
        end else if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_o = '0;
        end else if ((BYPASS != 0) && we1_i && (waddr1_i == raddr_i)) begin
            rdata_o = wdata1_i;
        end else if ((BYPASS != 0) && we0_i && (waddr0_i == raddr_i)) begin
            rdata_o = wdata0_i;
        end else begin
            rdata_o = mem_i[raddr_i];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NUM_RD async read ports, two write lanes (lane 1 wins on
// collision), hardwired zero entry and a sequential clear sweep.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_req,
    output logic                          ready,
    input  logic                          we0,
    input  logic [ADDR_SIZE-1:0]          waddr0,
    input  logic [WORD_SIZE-1:0]          wdata0,
    input  logic                          we1,
    input  logic [ADDR_SIZE-1:0]          waddr1,
    input  logic [WORD_SIZE-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_SIZE-1:0]   raddr,
    output logic [NUM_RD*WORD_SIZE-1:0]   rdata
);

    localparam int DEPTH = rf_depth(ADDR_SIZE);
    localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(DEPTH - 1);

    rf_state_e                     state_q, state_d;
    logic [ADDR_SIZE-1:0]          clr_ptr_q, clr_ptr_d;
    logic                          ready_q;
    logic [DEPTH-1:0][WORD_SIZE-1:0] mem_q;

    logic wr_en0, wr_en1;

    // Writes only land while idle; the zero entry drops them when hardwired.
    assign wr_en0 = we0 && (state_q == RF_IDLE) && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr_en1 = we1 && (state_q == RF_IDLE) && !((ZERO_REG != 0) && (waddr1 == '0));
    assign ready  = ready_q;

    // Sweep controller next state: clr_req starts a sweep, last pointer ends it.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            RF_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d   = RF_IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Control registers; ready tracks the state that is being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= (state_d == RF_IDLE);
        end
    end

    // Storage: sweep zeroes one entry per cycle, otherwise lane 0 then lane 1
    // so that lane 1 overrides a same-address lane 0 write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else begin
                if (wr_en0) mem_q[waddr0] <= wdata0;
                if (wr_en1) mem_q[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .ADDR_SIZE (ADDR_SIZE),
            .WORD_SIZE (WORD_SIZE),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_rd (
            .ready_i  (ready_q),
            .raddr_i  (raddr[rf_slice_lo(k, ADDR_SIZE) +: ADDR_SIZE]),
            .we0_i    (we0),
            .waddr0_i (waddr0),
            .wdata0_i (wdata0),
            .we1_i    (we1),
            .waddr1_i (waddr1),
            .wdata1_i (wdata1),
            .mem_i    (mem_q),
            .rdata_o  (rdata[rf_slice_lo(k, WORD_SIZE) +: WORD_SIZE])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 2-port bypassing instance and a 4-port non-bypassing
// instance share all write/control stimulus and are checked against one
// array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, clr_req, we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  rd [4];
    logic [9:0]  raddr2;
    logic [19:0] raddr4;
    logic [63:0] rdata2;
    logic [127:0] rdata4;
    logic        ready2, ready4;

    int n_cmp = 0;
    int n_fail = 0;
    int not_ready_cnt = 0;

    // Reference model: contents plus number of cycles still not ready.
    logic [31:0] m_mem [32];
    int          m_busy = 32;

    always #5 clk = ~clk;

    assign raddr2 = {rd[1], rd[0]};
    assign raddr4 = {rd[3], rd[2], rd[1], rd[0]};

    regfile_mp #(.ADDR_SIZE(5), .WORD_SIZE(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready2),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr2), .rdata(rdata2)
    );

    regfile_mp #(.ADDR_SIZE(5), .WORD_SIZE(32), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) dut4 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready4),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr4), .rdata(rdata4)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (m_busy != 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we1 && waddr1 == a) return wdata1;
        if (byp && we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_busy = 32;
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (we0 && waddr0 != 5'd0) m_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 5'd0) m_mem[waddr1] = wdata1;
            if (clr_req) begin
                m_busy = 32;
                for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // One clock: check every output at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        chk("ready2", {31'b0, ready2}, {31'b0, m_busy == 0});
        chk("ready4", {31'b0, ready4}, {31'b0, m_busy == 0});
        for (int k = 0; k < 2; k++) chk($sformatf("rd2_p%0d_a%0d", k, rd[k]), rdata2[k*32 +: 32], exp_rd(rd[k], 1'b1));
        for (int k = 0; k < 4; k++) chk($sformatf("rd4_p%0d_a%0d", k, rd[k]), rdata4[k*32 +: 32], exp_rd(rd[k], 1'b0));
        if (ready2 !== 1'b1) not_ready_cnt++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && ready2 !== 1'b1; i++) tick();
        chk(tag, not_ready_cnt, 32);
    endtask

    initial begin
        idle_inputs();
        for (int k = 0; k < 4; k++) rd[k] = 5'(k);

        // Reset: first edge unchecked since nothing is defined before it.
        rst = 1'b1;
        @(posedge clk); model_edge(); #1;
        rst = 1'b0;
        chk("rst_ready", {31'b0, ready2}, 32'h0);
        not_ready_cnt = 0;
        wait_ready("rst_sweep_len");
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) rd[k] = 5'(i * 4 + k);
            tick();
        end

        // Dual write to distinct addresses, then read back.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5_0001;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h0000_BEEF;
        rd[0] = 5'd3; rd[1] = 5'd7; rd[2] = 5'd3; rd[3] = 5'd7;
        #1;
        chk("dual_byp3", rdata2[31:0], 32'hA5A5_0001);
        chk("dual_old7", rdata4[63:32], 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("dual_rd3", rdata2[31:0], 32'hA5A5_0001);
        chk("dual_rd7", rdata4[63:32], 32'h0000_BEEF);
        tick();

        // Same-address collision: lane 1 wins in bypass and in storage.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1111;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h2222;
        rd[0] = 5'd9; rd[1] = 5'd9; rd[2] = 5'd9; rd[3] = 5'd9;
        #1;
        chk("coll_byp", rdata2[31:0], 32'h2222);
        tick();
        idle_inputs();
        #1;
        chk("coll_rd", rdata4[31:0], 32'h2222);
        tick();

        // Zero register on both lanes.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) rd[k] = 5'd0;
        #1;
        chk("zero_byp", rdata2[31:0], 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("zero_rd", rdata4[31:0], 32'h0);
        tick();

        // Fill every entry, then sweep with writes attempted during it.
        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1; waddr0 = 5'(2 * i);     wdata0 = $urandom;
            we1 = 1'b1; waddr1 = 5'(2 * i + 1); wdata1 = $urandom;
            for (int k = 0; k < 4; k++) rd[k] = 5'($urandom_range(0, 31));
            tick();
        end
        idle_inputs();
        rd[0] = 5'd31; rd[1] = 5'd1;
        #1;
        chk("fill_nonzero", {31'b0, rdata4[31:0] != 32'h0}, 32'h1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        not_ready_cnt = 0;
        for (int i = 0; i < 100 && ready2 !== 1'b1; i++) begin
            we0 = 1'b1; waddr0 = 5'($urandom_range(1, 31)); wdata0 = $urandom;
            we1 = 1'b1; waddr1 = 5'($urandom_range(1, 31)); wdata1 = $urandom;
            for (int k = 0; k < 4; k++) rd[k] = 5'($urandom_range(0, 31));
            tick();
        end
        chk("clr_sweep_len", not_ready_cnt, 32);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) rd[k] = 5'(i * 4 + k);
            tick();
        end

        // Reset at sweep cycle 10 restarts a full-length sweep.
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFE_0012;
        clr_req = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        not_ready_cnt = 0;
        wait_ready("midrst_sweep_len");
        rd[0] = 5'd12; rd[2] = 5'd12;
        tick();

        // Randomized traffic with occasional sweeps and resets.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we0 = $urandom_range(0, 1); waddr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
            we1 = $urandom_range(0, 1); waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            wdata1 = $urandom;
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: rd[k] = waddr0;
                    1: rd[k] = waddr1;
                    default: rd[k] = 5'($urandom_range(0, 31));
                endcase
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
